// File: rtl/data_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_ram_pkg
//  Description : Shared widths, FSM state encoding and port indices for the
//                data RAM arbiter and related bus arbiters.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_ram_pkg;

    localparam int c_DATA_W = 8;
    localparam int c_ADDR_W = 1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = c_ST_IDLE,
        ACCESS = c_ST_ACCESS,
        RESP   = c_ST_RESP
    } state_t;

    localparam logic c_M0 = 1'b0;
    localparam logic c_M1 = 1'b1;

endpackage : data_ram_pkg
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick2
//  Description : Combinational two-way round-robin picker. A lone requester
//                wins; on a tie the port that did not own last time wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_owner,
    output logic o_valid,
    output logic o_owner
);

    // Port 1 wins when it is the only requester, or on a tie after port 0 owned
    always_comb begin
        o_valid = i_req0 | i_req1;
        o_owner = i_req1 & (~i_req0 | ~i_last_owner);
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/data_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : data_ram_arbiter
//  Description : Round-robin req/gnt arbiter sharing the single-port data RAM
//                between the CPU load/store unit (port 0) and the I/O / debug
//                loader (port 1). All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_ram_arbiter
    import data_ram_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    state_t            r_state,      w_state_nxt;
    logic              r_owner,      w_owner_nxt;
    logic              r_we,         w_we_nxt;
    logic              r_last_owner, w_last_owner_nxt;
    logic              r_m0_gnt,     w_m0_gnt_nxt;
    logic              r_m1_gnt,     w_m1_gnt_nxt;
    logic              r_m0_rvalid,  w_m0_rvalid_nxt;
    logic              r_m1_rvalid,  w_m1_rvalid_nxt;
    logic [DATA_W-1:0] r_m0_rdata,   w_m0_rdata_nxt;
    logic [DATA_W-1:0] r_m1_rdata,   w_m1_rdata_nxt;
    logic [DATA_W-1:0] r_ram_data,   w_ram_data_nxt;
    logic [ADDR_W-1:0] r_ram_addr,   w_ram_addr_nxt;
    logic              r_ram_we,     w_ram_we_nxt;

    logic              w_pick_valid;
    logic              w_pick_owner;

    rr_pick2 u_rr_pick2 (
        .i_req0       (m0_req),
        .i_req1       (m1_req),
        .i_last_owner (r_last_owner),
        .o_valid      (w_pick_valid),
        .o_owner      (w_pick_owner)
    );

    // Next-state and next-output logic; the RAM address/data registers double
    // as the latched transaction, so the access appears on the RAM pins in
    // the cycle after arbitration.
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_we_nxt         = r_we;
        w_last_owner_nxt = r_last_owner;
        w_m0_gnt_nxt     = 1'b0;
        w_m1_gnt_nxt     = 1'b0;
        w_m0_rvalid_nxt  = 1'b0;
        w_m1_rvalid_nxt  = 1'b0;
        w_m0_rdata_nxt   = r_m0_rdata;
        w_m1_rdata_nxt   = r_m1_rdata;
        w_ram_data_nxt   = r_ram_data;
        w_ram_addr_nxt   = r_ram_addr;
        w_ram_we_nxt     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt  = ACCESS;
                    w_owner_nxt  = w_pick_owner;
                    if (w_pick_owner == c_M1) begin
                        w_we_nxt       = m1_we;
                        w_ram_we_nxt   = m1_we;
                        w_ram_addr_nxt = m1_addr;
                        w_ram_data_nxt = m1_wdata;
                        w_m1_gnt_nxt   = 1'b1;
                    end else begin
                        w_we_nxt       = m0_we;
                        w_ram_we_nxt   = m0_we;
                        w_ram_addr_nxt = m0_addr;
                        w_ram_data_nxt = m0_wdata;
                        w_m0_gnt_nxt   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // Write lands in the RAM at the end of this cycle
                w_last_owner_nxt = r_owner;
                w_state_nxt      = r_we ? IDLE : RESP;
            end
            RESP: begin
                // RAM has registered the address; capture its output now
                w_state_nxt = IDLE;
                if (r_owner == c_M1) begin
                    w_m1_rdata_nxt  = ram_q;
                    w_m1_rvalid_nxt = 1'b1;
                end else begin
                    w_m0_rdata_nxt  = ram_q;
                    w_m0_rvalid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves port 0 winning the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= c_M0;
            r_we         <= 1'b0;
            r_last_owner <= c_M1;
            r_m0_gnt     <= 1'b0;
            r_m1_gnt     <= 1'b0;
            r_m0_rvalid  <= 1'b0;
            r_m1_rvalid  <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
            r_ram_data   <= '0;
            r_ram_addr   <= '0;
            r_ram_we     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_we         <= w_we_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_m0_gnt     <= w_m0_gnt_nxt;
            r_m1_gnt     <= w_m1_gnt_nxt;
            r_m0_rvalid  <= w_m0_rvalid_nxt;
            r_m1_rvalid  <= w_m1_rvalid_nxt;
            r_m0_rdata   <= w_m0_rdata_nxt;
            r_m1_rdata   <= w_m1_rdata_nxt;
            r_ram_data   <= w_ram_data_nxt;
            r_ram_addr   <= w_ram_addr_nxt;
            r_ram_we     <= w_ram_we_nxt;
        end
    end

    assign m0_gnt    = r_m0_gnt;
    assign m1_gnt    = r_m1_gnt;
    assign m0_rvalid = r_m0_rvalid;
    assign m1_rvalid = r_m1_rvalid;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign ram_data  = r_ram_data;
    assign ram_addr  = r_ram_addr;
    assign ram_we    = r_ram_we;

endmodule : data_ram_arbiter
`default_nettype wire

// File: tb/tb_data_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_ram_arbiter
//  Description : Directed self-checking bench for data_ram_arbiter with a
//                behavioural registered-address RAM attached.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_ram_arbiter;

    localparam int c_DW = 8;
    localparam int c_AW = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            m0_req, m0_we, m1_req, m1_we;
    logic [c_AW-1:0] m0_addr, m1_addr;
    logic [c_DW-1:0] m0_wdata, m1_wdata;
    logic            m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [c_DW-1:0] m0_rdata, m1_rdata;
    logic [c_DW-1:0] ram_data, ram_q;
    logic [c_AW-1:0] ram_addr;
    logic            ram_we;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_ram_arbiter #(.DATA_W(c_DW), .ADDR_W(c_AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .ram_data  (ram_data),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_q     (ram_q)
    );

    // Behavioural data RAM: write and address register on posedge, read
    // output combinational from the registered address
    logic [c_DW-1:0] r_mem [2];
    logic [c_AW-1:0] r_ra;
    always @(posedge clk) begin
        if (ram_we) r_mem[ram_addr] <= ram_data;
        r_ra <= ram_addr;
    end
    assign ram_q = r_mem[r_ra];

    task automatic check_vec(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-port transfer with bounded waits; ends in an IDLE cycle
    task automatic xfer(input logic port, input logic we,
                        input logic [c_AW-1:0] addr, input logic [c_DW-1:0] wd,
                        output logic [c_DW-1:0] rd);
        int n;
        rd = '0;
        if (port) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd;
        end
        n = 0;
        do begin tick(); n++; end
        while (!(port ? m1_gnt : m0_gnt) && n < 20);
        if (!(port ? m1_gnt : m0_gnt)) check_vec("xfer_gnt_timeout", 0, 1);
        m0_req = 1'b0;
        m1_req = 1'b0;
        if (we) begin
            tick();
        end else begin
            n = 0;
            do begin tick(); n++; end
            while (!(port ? m1_rvalid : m0_rvalid) && n < 20);
            if (!(port ? m1_rvalid : m0_rvalid)) check_vec("xfer_rvalid_timeout", 0, 1);
            rd = port ? m1_rdata : m0_rdata;
        end
    endtask

    initial begin
        logic [c_DW-1:0] rd;
        int ngr, nwe;

        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset then idle
        check_vec("rst_rdata", {m0_rdata, m1_rdata, ram_data}, 0);
        for (int i = 0; i < 5; i++) begin
            check_vec("idle_outs", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_we, ram_addr}, 0);
            tick();
        end

        // Port 0 write A5 to addr 1
        m0_req = 1; m0_we = 1; m0_addr = 1; m0_wdata = 8'hA5;
        tick();
        check_vec("wr_gnt", {m0_gnt, m1_gnt, ram_we}, 3'b101);
        check_vec("wr_addr", ram_addr, 1);
        check_vec("wr_data", ram_data, 8'hA5);
        m0_req = 0;
        tick();
        check_vec("wr_done", {m0_gnt, ram_we}, 0);

        // Port 0 read addr 1, data at k+3
        m0_req = 1; m0_we = 0; m0_addr = 1;
        tick();
        check_vec("rd_gnt", {m0_gnt, ram_we, ram_addr}, 3'b101);
        m0_req = 0;
        tick();
        check_vec("rd_resp_cycle", m0_rvalid, 0);
        tick();
        check_vec("rd_rvalid", m0_rvalid, 1);
        check_vec("rd_rdata", m0_rdata, 8'hA5);
        tick();
        check_vec("rd_rvalid_pulse", m0_rvalid, 0);

        // Simultaneous reads after reset
        xfer(1'b0, 1'b1, 1'b0, 8'h3C, rd);
        xfer(1'b1, 1'b1, 1'b1, 8'hC3, rd);
        rst = 1; tick(); rst = 0;
        m0_req = 1; m0_we = 0; m0_addr = 0;
        m1_req = 1; m1_we = 0; m1_addr = 1;
        tick();
        check_vec("sim_gnt_first", {m0_gnt, m1_gnt}, 2'b10);
        check_vec("sim_addr_first", ram_addr, 0);
        m0_req = 0;
        tick(); tick();
        check_vec("sim_rvalid0", {m0_rvalid, m1_rvalid}, 2'b10);
        check_vec("sim_rdata0", m0_rdata, 8'h3C);
        check_vec("sim_rdata1_held", m1_rdata, 8'h00);
        tick();
        check_vec("sim_gnt_second", {m0_gnt, m1_gnt}, 2'b01);
        check_vec("sim_addr_second", ram_addr, 1);
        m1_req = 0;
        tick(); tick();
        check_vec("sim_rvalid1", {m0_rvalid, m1_rvalid}, 2'b01);
        check_vec("sim_rdata1", m1_rdata, 8'hC3);
        check_vec("sim_rdata0_held", m0_rdata, 8'h3C);

        // Fairness with both ports holding writes
        m0_req = 1; m0_we = 1; m0_addr = 0; m0_wdata = 8'h11;
        m1_req = 1; m1_we = 1; m1_addr = 1; m1_wdata = 8'h22;
        ngr = 0; nwe = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (m0_gnt || m1_gnt) begin
                check_vec("fair_order", {m0_gnt, m1_gnt}, (ngr % 2 == 0) ? 2'b10 : 2'b01);
                check_vec("fair_data", ram_data, m1_gnt ? 8'h22 : 8'h11);
                ngr++;
            end
            if (ram_we) nwe++;
            if (c == 15) begin m0_req = 0; m1_req = 0; end
        end
        check_vec("fair_grants", ngr, 8);
        check_vec("fair_we_count", nwe, 8);
        tick();
        check_vec("fair_quiet", {m0_gnt, m1_gnt, ram_we}, 0);

        // Cross-port RAW, m1 write granted first
        xfer(1'b0, 1'b1, 1'b0, 8'h77, rd);
        m0_req = 1; m0_we = 0; m0_addr = 0;
        m1_req = 1; m1_we = 1; m1_addr = 0; m1_wdata = 8'h5A;
        tick();
        check_vec("raw1_gnt", {m0_gnt, m1_gnt, ram_we}, 3'b011);
        check_vec("raw1_wdata", ram_data, 8'h5A);
        m1_req = 0;
        tick(); tick();
        check_vec("raw1_gnt0", m0_gnt, 1);
        m0_req = 0;
        tick(); tick();
        check_vec("raw1_rvalid", m0_rvalid, 1);
        check_vec("raw1_rdata", m0_rdata, 8'h5A);

        // Cross-port RAW, m0 read granted first sees the old value
        xfer(1'b1, 1'b1, 1'b1, 8'h99, rd);
        m0_req = 1; m0_we = 0; m0_addr = 0;
        m1_req = 1; m1_we = 1; m1_addr = 0; m1_wdata = 8'hE7;
        tick();
        check_vec("raw2_gnt", {m0_gnt, m1_gnt}, 2'b10);
        m0_req = 0;
        tick(); tick();
        check_vec("raw2_rvalid", m0_rvalid, 1);
        check_vec("raw2_rdata_old", m0_rdata, 8'h5A);
        tick();
        check_vec("raw2_gnt1", {m1_gnt, ram_we}, 2'b11);
        check_vec("raw2_wdata", ram_data, 8'hE7);
        m1_req = 0;
        tick();
        xfer(1'b0, 1'b0, 1'b0, 8'h00, rd);
        check_vec("raw2_readback", rd, 8'hE7);

        // Reset during RESP of a port 0 read
        m0_req = 1; m0_we = 0; m0_addr = 1;
        tick();
        check_vec("rstm_gnt", m0_gnt, 1);
        m0_req = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        check_vec("rstm_outs", {m0_rvalid, m1_rvalid, ram_we}, 0);
        check_vec("rstm_rdata", m0_rdata, 0);
        tick();
        check_vec("rstm_no_late_rvalid", {m0_rvalid, m1_rvalid}, 0);
        m0_req = 1; m0_we = 1; m0_addr = 1; m0_wdata = 8'h33;
        m1_req = 1; m1_we = 1; m1_addr = 0; m1_wdata = 8'h44;
        tick();
        check_vec("rstm_tie_port0", {m0_gnt, m1_gnt}, 2'b10);
        m0_req = 0;
        tick(); tick();
        check_vec("rstm_m1_gnt", {m0_gnt, m1_gnt}, 2'b01);
        check_vec("rstm_m1_addr", ram_addr, 0);
        m1_req = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_data_ram_arbiter
`default_nettype wire
